reg_wr_queue: RTL and testbench



---
 rtl/reg_wr_pkg.sv | 28 ++
 rtl/reg_wr_fifo.sv | 96 +++++++++
 rtl/reg_wr_queue.sv | 94 +++++++++
 tb/tb_reg_wr_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wr_pkg.sv
// -----------------------------------------------------------------------------
// reg_wr_pkg
// Shared types and helpers for the register-bank write path.
//   NUM_REGS   : number of registers in the bank (8)
//   ADDR_W     : register index width (3)
//   DATA_W     : register data width (32)
//   wr_entry_t : one queued write {addr, data}
//   onehot8()  : register index -> one-hot bank write enable
// -----------------------------------------------------------------------------
package reg_wr_pkg;

   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

   function automatic logic [NUM_REGS-1:0] onehot8(input logic [ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] vec;
      vec       = '0;
      vec[addr] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/reg_wr_fifo.sv
// -----------------------------------------------------------------------------
// reg_wr_fifo
// Synchronous DEPTH-entry FIFO of wr_entry_t with async active-low reset.
// Pushes while full and pops while empty are ignored.
// Optional feature macro: REG_WR_PENDING_EN exposes the raw storage and a
// per-slot valid mask so the parent can summarise what is queued.
//   clk, reset_n      : clock, asynchronous active-low reset
//   push, push_entry  : write push_entry at the tail
//   pop               : discard the head entry
//   head_entry        : entry at the head (meaningful when !empty)
//   count             : occupancy, 0..DEPTH
//   full, empty       : occupancy flags
//   entries, valid_mask (macro only) : storage and occupied-slot mask
// -----------------------------------------------------------------------------
module reg_wr_fifo
   import reg_wr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  wr_entry_t              push_entry,
   input  logic                   pop,
   output wr_entry_t              head_entry,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
`ifdef REG_WR_PENDING_EN
   ,
   output wr_entry_t              entries [DEPTH],
   output logic [DEPTH-1:0]       valid_mask
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wr_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + PTR_W'(1);
         if (do_pop)  head <= head + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; slots are only read once the pointers say
   // they hold data, and leaving it unreset lets it map to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= push_entry;
   end

   assign head_entry = mem[head];

`ifdef REG_WR_PENDING_EN
   logic [PTR_W-1:0] offset;

   assign entries = mem;

   // Slot i is occupied when its distance from head is below the occupancy.
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      valid_mask = '0;
      offset     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset        = PTR_W'(i) - head;
         valid_mask[i] = ({1'b0, offset} < count);
      end
   end
`endif

endmodule

// File: rtl/reg_wr_queue.sv
// -----------------------------------------------------------------------------
// reg_wr_queue
// Buffered write-port front end for the 8 x 32-bit register bank. Requests
// are accepted over valid/ready into a DEPTH-entry FIFO and drained one per
// cycle as a registered one-hot write enable plus shared write data.
// Optional feature macro: REG_WR_PENDING_EN adds the pending[7:0] output.
//   clk, reset_n        : clock, asynchronous active-low reset
//   wr_valid, wr_ready  : request handshake (wr_ready = count < DEPTH)
//   wr_addr, wr_data    : target register index and data
//   drain_hold          : 1 = do not pop at the next edge
//   rf_en, rf_data      : registered bank write enable (one-hot or zero), data
//   count               : FIFO occupancy
//   pending (macro only): bit i = write to register i queued or on rf_en
// -----------------------------------------------------------------------------
module reg_wr_queue
   import reg_wr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   drain_hold,
   output logic [NUM_REGS-1:0]    rf_en,
   output logic [DATA_W-1:0]      rf_data,
   output logic [$clog2(DEPTH):0] count
`ifdef REG_WR_PENDING_EN
   ,
   output logic [NUM_REGS-1:0]    pending
`endif
);

   wr_entry_t push_entry;
   wr_entry_t head_entry;
   logic      full;
   logic      empty;
   logic      push;
   logic      pop;

`ifdef REG_WR_PENDING_EN
   wr_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] valid_mask;
`endif

   // Ready depends only on registered occupancy: no pass-through when full.
   assign wr_ready   = !full;
   assign push       = wr_valid && wr_ready;
   assign pop        = !empty && !drain_hold;
   assign push_entry = '{addr: wr_addr, data: wr_data};

   reg_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (count),
      .full       (full),
      .empty      (empty)
`ifdef REG_WR_PENDING_EN
      ,
      .entries    (entries),
      .valid_mask (valid_mask)
`endif
   );

   // An entry pushed this edge is not yet at head_entry, so it can only pop
   // on a later edge. rf_data holds its value between writes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_en   <= '0;
         rf_data <= '0;
      end else if (pop) begin
         rf_en   <= onehot8(head_entry.addr);
         rf_data <= head_entry.data;
      end else begin
         rf_en   <= '0;
      end
   end

`ifdef REG_WR_PENDING_EN
   always_comb begin
      pending = rf_en;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_mask[i]) pending = pending | onehot8(entries[i].addr);
      end
   end
`endif

endmodule

// File: tb/tb_reg_wr_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_wr_queue
// Self-checking bench for reg_wr_queue. A queue-based model of the write
// buffer is compared against the DUT on every falling edge; directed
// scenarios add literal expectations. Honours REG_WR_PENDING_EN.
// -----------------------------------------------------------------------------
module tb_reg_wr_queue;
   import reg_wr_pkg::*;

   localparam int DEPTH = 4;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b1;
   logic        wr_valid   = 1'b0;
   logic [2:0]  wr_addr    = '0;
   logic [31:0] wr_data    = '0;
   logic        drain_hold = 1'b0;
   logic        wr_ready;
   logic [7:0]  rf_en;
   logic [31:0] rf_data;
   logic [2:0]  count;
`ifdef REG_WR_PENDING_EN
   logic [7:0]  pending;
`endif

   int errors = 0;
   int checks = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   reg_wr_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .drain_hold (drain_hold),
      .rf_en      (rf_en),
      .rf_data    (rf_data),
      .count      (count)
`ifdef REG_WR_PENDING_EN
      ,
      .pending    (pending)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [2:0]  a;
      logic [31:0] d;
   } req_t;

   req_t        q[$];
   logic [7:0]  m_en   = '0;
   logic [31:0] m_data = '0;

   always @(posedge clk or negedge reset_n) begin : model
      bit do_pop;
      bit do_push;
      if (!reset_n) begin
         q.delete();
         m_en   = '0;
         m_data = '0;
      end else begin
         do_pop  = (q.size() > 0) && !drain_hold;
         do_push = wr_valid && (q.size() < DEPTH);
         if (do_pop) begin
            m_en   = 8'd1 << q[0].a;
            m_data = q[0].d;
            void'(q.pop_front());
         end else begin
            m_en = '0;
         end
         if (do_push) q.push_back('{wr_addr, wr_data});
      end
   end

   function automatic logic [7:0] m_pending();
      logic [7:0] r;
      r = m_en;
      foreach (q[i]) r = r | (8'd1 << q[i].a);
      return r;
   endfunction

   always @(negedge clk) begin
      if (cmp_on) begin
         check("cmp_rf_en", 32'(rf_en), 32'(m_en));
         check("cmp_rf_data", rf_data, m_data);
         check("cmp_count", 32'(count), 32'(q.size()));
         check("cmp_wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
`ifdef REG_WR_PENDING_EN
         check("cmp_pending", 32'(pending), 32'(m_pending()));
`endif
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a falling edge; applies inputs, lets one rising edge
   // happen, returns just after the next falling edge.
   task automatic drive(input logic v, input logic [2:0] a, input logic [31:0] d,
                        input logic h);
      wr_valid   = v;
      wr_addr    = a;
      wr_data    = d;
      drain_hold = h;
      @(negedge clk);
      #1;
   endtask

   int unsigned pushes [6] = '{3, 4, 5, 6, 7, 0};
   int unsigned pops   [8] = '{1, 2, 3, 4, 5, 6, 7, 0};

   initial begin
      // Reset state
      #1 reset_n = 1'b0;
      #1 cmp_on = 1'b1;
      check("reset_rf_en", 32'(rf_en), 32'h0);
      check("reset_rf_data", rf_data, 32'h0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_wr_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      #1 reset_n = 1'b1;

      // Single write: pops one edge after acceptance, enable lasts one cycle
      drive(1'b1, 3'd5, 32'hDEAD_BEEF, 1'b0);
      check("single_no_same_edge", 32'(rf_en), 32'h0);
      check("single_count", 32'(count), 32'd1);
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("single_rf_en", 32'(rf_en), 32'h20);
      check("single_rf_data", rf_data, 32'hDEAD_BEEF);
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("single_rf_en_off", 32'(rf_en), 32'h0);
      check("single_rf_data_held", rf_data, 32'hDEAD_BEEF);

      // Fill under hold, then a refused fifth request
      for (int i = 0; i < 4; i++) drive(1'b1, 3'(i), 32'hA000_0000 + 32'(i), 1'b1);
      check("fill_count", 32'(count), 32'd4);
      check("fill_wr_ready", 32'(wr_ready), 32'd0);
`ifdef REG_WR_PENDING_EN
      check("fill_pending", 32'(pending), 32'h0F);
`endif
      drive(1'b1, 3'd4, 32'hBAD0_BAD0, 1'b1);
      check("fifth_count", 32'(count), 32'd4);
      check("fifth_rf_en", 32'(rf_en), 32'h0);

      // Release hold: 01,02,04,08 then 00
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 3'd0, 32'h0, 1'b0);
         check("drain_rf_en", 32'(rf_en), 32'h1 << i);
         check("drain_rf_data", rf_data, 32'hA000_0000 + 32'(i));
         if (i == 0) check("drain_wr_ready", 32'(wr_ready), 32'd1);
      end
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("drain_done", 32'(rf_en), 32'h0);

      // Sustained push+pop at count = 2, through a pointer wrap
      drive(1'b1, 3'd1, 32'hC0DE_0001, 1'b1);
      drive(1'b1, 3'd2, 32'hC0DE_0002, 1'b1);
      check("pp_preload", 32'(count), 32'd2);
      for (int k = 0; k < 8; k++) begin
         if (k < 6) drive(1'b1, 3'(pushes[k]), 32'hC0DE_0000 + pushes[k], 1'b0);
         else       drive(1'b0, 3'd0, 32'h0, 1'b0);
         check("pp_rf_en", 32'(rf_en), 32'h1 << pops[k]);
         check("pp_rf_data", rf_data, 32'hC0DE_0000 + pops[k]);
         if (k < 6) check("pp_count", 32'(count), 32'd2);
      end
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("pp_done", 32'(rf_en), 32'h0);

      // Repeated address is not merged; pending summary
      drive(1'b1, 3'd7, 32'h7777_0001, 1'b1);
      drive(1'b1, 3'd7, 32'h7777_0002, 1'b1);
      drive(1'b1, 3'd2, 32'h2222_0003, 1'b1);
`ifdef REG_WR_PENDING_EN
      check("pend_queued", 32'(pending), 32'h84);
`endif
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("pend_rf_en0", 32'(rf_en), 32'h80);
      check("pend_rf_data0", rf_data, 32'h7777_0001);
`ifdef REG_WR_PENDING_EN
      check("pend_p0", 32'(pending), 32'h84);
`endif
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("pend_rf_en1", 32'(rf_en), 32'h80);
      check("pend_rf_data1", rf_data, 32'h7777_0002);
`ifdef REG_WR_PENDING_EN
      check("pend_p1", 32'(pending), 32'h84);
`endif
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("pend_rf_en2", 32'(rf_en), 32'h04);
`ifdef REG_WR_PENDING_EN
      check("pend_p2", 32'(pending), 32'h04);
`endif
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("pend_rf_en3", 32'(rf_en), 32'h00);
`ifdef REG_WR_PENDING_EN
      check("pend_p3", 32'(pending), 32'h00);
`endif

      // Asynchronous reset mid-drain with three entries still queued
      for (int i = 4; i < 8; i++) drive(1'b1, 3'(i), 32'h5000_0000 + 32'(i), 1'b1);
      drive(1'b0, 3'd0, 32'h0, 1'b0);
      check("pre_rst_rf_en", 32'(rf_en), 32'h10);
      check("pre_rst_count", 32'(count), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      check("rst_rf_en", 32'(rf_en), 32'h0);
      check("rst_rf_data", rf_data, 32'h0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
`ifdef REG_WR_PENDING_EN
      check("rst_pending", 32'(pending), 32'h0);
`endif
      @(negedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 3'd0, 32'h0, 1'b0);
         check("post_rst_no_stale", 32'(rf_en), 32'h0);
      end

      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
